// File: rtl/mem_pkg.sv
// Shared defaults and the state encoding for the simple-RAM-port initiator.
package mem_pkg;

  localparam int MEM_ADDR_WIDTH = 4;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_TIMEOUT    = 8;
  localparam int MEM_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_initiator.sv
// Initiator for the simple RAM port: one command at a time from a valid/ready
// request channel, read results (or a timeout) returned on a valid/ready response channel.
//
//   state | meaning
//   IDLE  | ready for a command
//   WRITE | mem_en pulse on the RAM port, one cycle
//   READ  | address held, waiting for mem_valid_out or the timeout
//   RESP  | read result held until rsp_ready
module mem_initiator
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int TIMEOUT    = MEM_TIMEOUT,
  parameter int CNT_WIDTH  = MEM_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_valid_out,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t                state, state_nx;
  logic [TW-1:0]         timer, timer_nx;
  logic                  rd_first, rd_first_nx;
  logic                  mem_en_nx;
  logic [ADDR_WIDTH-1:0] mem_address_nx;
  logic [DATA_WIDTH-1:0] mem_data_in_nx;
  logic                  rsp_valid_nx;
  logic [DATA_WIDTH-1:0] rsp_rdata_nx;
  logic [ADDR_WIDTH-1:0] rsp_addr_nx;
  logic                  rsp_err_nx;
  logic [CNT_WIDTH-1:0]  wr_count_nx, rd_count_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      rd_first    <= 1'b0;
      mem_en      <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_addr    <= '0;
      rsp_err     <= 1'b0;
      wr_count    <= '0;
      rd_count    <= '0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      rd_first    <= rd_first_nx;
      mem_en      <= mem_en_nx;
      mem_address <= mem_address_nx;
      mem_data_in <= mem_data_in_nx;
      rsp_valid   <= rsp_valid_nx;
      rsp_rdata   <= rsp_rdata_nx;
      rsp_addr    <= rsp_addr_nx;
      rsp_err     <= rsp_err_nx;
      wr_count    <= wr_count_nx;
      rd_count    <= rd_count_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    timer_nx       = timer;
    rd_first_nx    = rd_first;
    mem_en_nx      = mem_en;
    mem_address_nx = mem_address;
    mem_data_in_nx = mem_data_in;
    rsp_valid_nx   = rsp_valid;
    rsp_rdata_nx   = rsp_rdata;
    rsp_addr_nx    = rsp_addr;
    rsp_err_nx     = rsp_err;
    wr_count_nx    = wr_count;
    rd_count_nx    = rd_count;
    req_ready      = (state == IDLE);
    busy           = (state != IDLE);

    case (state)
      IDLE: begin
        if (req_valid) begin
          mem_address_nx = req_addr;
          if (req_write) begin
            mem_en_nx      = 1'b1;
            mem_data_in_nx = req_wdata;
            state_nx       = WRITE;
          end else begin
            mem_en_nx   = 1'b0;
            timer_nx    = '0;
            rd_first_nx = 1'b1;
            state_nx    = READ;
          end
        end
      end
      WRITE: begin
        mem_en_nx   = 1'b0;
        wr_count_nx = wr_count + CNT_WIDTH'(1);
        state_nx    = IDLE;
      end
      READ: begin
        // The first edge may still see valid left over from a previous access.
        if (rd_first) begin
          rd_first_nx = 1'b0;
        end else if (mem_valid_out) begin
          rsp_rdata_nx = mem_data_out;
          rsp_addr_nx  = mem_address;
          rsp_err_nx   = 1'b0;
          rsp_valid_nx = 1'b1;
          state_nx     = RESP;
        end else if (timer == TIMER_LAST) begin
          rsp_rdata_nx = '0;
          rsp_addr_nx  = mem_address;
          rsp_err_nx   = 1'b1;
          rsp_valid_nx = 1'b1;
          state_nx     = RESP;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nx = 1'b0;
          rd_count_nx  = rd_count + CNT_WIDTH'(1);
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Initiator (master) for the simple RAM port (en / address / data_in / data_out / valid_out).
- Accepts write and read commands over a valid/ready request channel and drives them onto the RAM port one at a time.
- Read results, or a read timeout, are returned on a valid/ready response channel.
- Sits between the stimulus/control logic and the RAM, on the opposite end of the RAM port from the memory.

Parameters:
ADDR_WIDTH, 4, RAM address width
DATA_WIDTH, 32, RAM data width
TIMEOUT, 8, max sampled cycles waiting for mem_valid_out on a read (>=2)
CNT_WIDTH, 16, width of transaction counters

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  command present
req_ready  output  1  command accepted this cycle when high with req_valid
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_WIDTH  command address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  read response present
rsp_ready  input  1  response consumed
rsp_rdata  output  DATA_WIDTH  read data (0 on error)
rsp_addr  output  ADDR_WIDTH  address of the read being answered
rsp_err  output  1  read timed out
mem_en  output  1  RAM write strobe
mem_address  output  ADDR_WIDTH  RAM address
mem_data_in  output  DATA_WIDTH  RAM write data
mem_data_out  input  DATA_WIDTH  RAM read data
mem_valid_out  input  1  RAM read data valid
busy  output  1  state != IDLE
wr_count  output  CNT_WIDTH  completed writes
rd_count  output  CNT_WIDTH  completed reads (including errors)

Behaviour:
- RAM protocol:
  - mem_en=1 for one cycle writes mem_data_in to mem_address.
  - mem_en=0 with mem_address held is a read; the RAM answers with mem_valid_out/mem_data_out.
- All outputs are registered except req_ready and busy, which are decoded from state.
- Reset (async, any state):
  - state=IDLE.
  - mem_en=0, mem_address=0, mem_data_in=0.
  - rsp_valid=0, rsp_rdata=0, rsp_addr=0, rsp_err=0.
  - Counters=0, timer=0.
  - An in-flight command or pending response is discarded.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid with req_write=1: next cycle mem_en=1, mem_address=req_addr, mem_data_in=req_wdata; go WRITE.
  - On req_valid with req_write=0: next cycle mem_en=0, mem_address=req_addr, timer=0; go READ.
- WRITE:
  - Lasts exactly one cycle, with req_ready=0.
  - Next edge: mem_en=0, wr_count+1, go IDLE.
  - Max write throughput is 1 per 2 cycles.
- READ:
  - req_ready=0.
  - mem_address is held.
  - mem_valid_out is ignored in the first READ cycle (the cycle the address is first driven), which prevents stale valid from a prior access.
  - From the second edge on, each edge behaves as follows:
    - if mem_valid_out=1: rsp_rdata=mem_data_out, rsp_addr=mem_address, rsp_err=0; go RESP.
    - else if timer==TIMEOUT-1: rsp_rdata=0, rsp_addr=mem_address, rsp_err=1; go RESP.
    - else timer+1.
  - Valid on the last allowed edge wins over timeout.
- RESP:
  - rsp_valid=1; rsp_rdata, rsp_addr and rsp_err stay stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0, rd_count+1, go IDLE.
  - A new request is not accepted in the same cycle; req_ready=0 in RESP.
- Read latency: request accept to rsp_valid is 3 cycles minimum, when the RAM answers on the first sampled edge.
- Counters wrap modulo 2^CNT_WIDTH with no saturation.
- mem_valid_out outside READ (second cycle onward) is ignored.

Decomposition:
- mem_pkg holds:
  - the state enum typedef (IDLE, WRITE, READ, RESP);
  - default ADDR_WIDTH/DATA_WIDTH constants, shared with the interface and the RAM;
  - the timeout default.
- Single module with no sub-module; the timer and counters are inline.

Test Plan:
- Write then read: req write addr 4'h3 data 32'hDEADBEEF, then read 4'h3.
  - Required: mem_en high exactly 1 cycle with mem_address=3, mem_data_in=DEADBEEF.
  - Then rsp_valid with rsp_rdata=DEADBEEF, rsp_addr=3, rsp_err=0; wr_count=1, rd_count=1.
- Read timeout: RAM model never asserts mem_valid_out, read addr 4'hA, TIMEOUT=8.
  - Required: rsp_valid 9 cycles after the READ entry edge, rsp_err=1, rsp_rdata=0, rsp_addr=A.
- Response backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid.
  - Required: rsp fields stable, req_ready=0, a new req_valid not accepted.
  - Accepted on the first cycle with rsp_ready=1.
- Stale/edge valid:
  - mem_valid_out=1 in the first READ cycle only: ignored, and the read ends with a timeout error.
  - mem_valid_out=1 on the 8th sampled edge: data returned with rsp_err=0.
- Back-to-back writes: 16 writes to addr 0..15 with req_valid held high.
  - Required: one accept every 2 cycles, wr_count=16, no mem_en pulse longer than 1 cycle.
- Reset mid-read: assert reset asynchronously (between edges) while in READ.
  - Required: all outputs at reset values immediately, busy=0 and no rsp_valid after release.
  - The next read completes normally.
